// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key_debounce block: per-channel FSM
// state encoding, hold-counter width and a counter-width helper.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int HOLD_W = 24;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: two-flop synchronizer, four-state debounce FSM
// and, when KEY_LONG_PRESS_EN is defined, a saturating long-press hold counter.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 200
`ifdef KEY_LONG_PRESS_EN
  , parameter int LONG_CNT   = 50000
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int            CW       = cnt_width(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic            r_sync1;
  logic            r_sync2;
  key_state_e      r_state;
  key_state_e      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_level;
  logic            w_level_nxt;
  logic            r_press;
  logic            w_press_nxt;
  logic            r_release;
  logic            w_release_nxt;

  // Two-flop synchronizer; idles at the released (high) pin level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, debounce counter and registered level/pulse outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next-state logic; a wait state exits at CNT_LAST, so the counter never wraps.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (r_sync2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_PRESSED;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = ST_PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);

  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_long;
  logic              w_long_nxt;

  // Hold counter and registered long-press pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_long <= w_long_nxt;
    end
  end

  // Counting starts the cycle after the press pulse; the release edge clears it,
  // so a long pulse can never coincide with a press or release pulse.
  always_comb begin
    w_hold_nxt = r_hold;
    w_long_nxt = 1'b0;
    if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_PRESS_WAIT)) begin
      w_hold_nxt = '0;
    end else if (r_state == ST_PRESS_WAIT) begin
      w_hold_nxt = '0;
    end else if (r_hold != HOLD_LAST) begin
      w_hold_nxt = r_hold + HOLD_W'(1);
      w_long_nxt = ((r_hold + HOLD_W'(1)) == HOLD_LAST);
    end else begin
      w_hold_nxt = r_hold;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer top: NKEYS independent key_debounce_ch instances.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NKEYS        = 2,
  parameter int DEBOUNCE_CNT = 200,
  parameter int LONG_CNT     = 50000
) (
  input  logic             CLK_IN,
  input  logic             rst,
  input  logic [NKEYS-1:0] KEY_FPGA,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_long
);

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
`ifdef KEY_LONG_PRESS_EN
      , .LONG_CNT   (LONG_CNT)
`endif
    ) u_ch (
      .i_clk     (CLK_IN),
      .i_rst_n   (rst),
      .i_key_n   (KEY_FPGA[g]),
      .o_level   (key_level[g]),
      .o_press   (key_press[g]),
      .o_release (key_release[g]),
      .o_long    (key_long[g])
    );
  end

endmodule
